// File: rtl/shift_result_fifo.sv
// shift_result_fifo: captures {left,right} shifter result pairs into a small
// FIFO and presents them as 16-bit words over a valid/ready handshake.
// Optional macro SHIFT_RESULT_FIFO_STATS_EN adds input stall statistics
// (stall_cnt, ovf_seen).
module shift_result_fifo #(
  parameter  int DEPTH       = 4,
  parameter  int ALMOST_FULL = DEPTH-1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_left,
  input  logic [7:0]    in_right,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [AW:0]   count,
  output logic          almost_full
`ifdef SHIFT_RESULT_FIFO_STATS_EN
  ,
  output logic [7:0]    stall_cnt,
  output logic [0:0]    ovf_seen
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(ALMOST_FULL);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push, pop;

  // Flags derive purely from occupancy; in_ready never looks at out_ready,
  // so a full FIFO refuses a push even when the head is popped that cycle.
  assign in_ready    = (count != FULL_CNT);
  assign out_valid   = (count != '0);
  assign almost_full = (count >= AF_CNT);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_data    = mem[rd_ptr];

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (push && resetn) mem[wr_ptr] <= {in_left, in_right};
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

`ifdef SHIFT_RESULT_FIFO_STATS_EN
  logic stall;
  assign stall = in_valid & ~in_ready;

  // Saturating stall counter; ovf_seen latches in the cycle the counter
  // reaches 0xFF and holds until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      ovf_seen  <= '0;
    end else if (stall && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
      if (stall_cnt == 8'hFE) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_result_fifo.sv
// Bench for shift_result_fifo: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_shift_result_fifo;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_left = '0;
  logic [7:0]  in_right = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic        almost_full;
`ifdef SHIFT_RESULT_FIFO_STATS_EN
  logic [7:0]  stall_cnt;
  logic [0:0]  ovf_seen;
`endif

  int checks = 0;
  int errors = 0;

  shift_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .almost_full(almost_full)
`ifdef SHIFT_RESULT_FIFO_STATS_EN
    , .stall_cnt(stall_cnt), .ovf_seen(ovf_seen)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [7:0]  l;
    logic [7:0]  r;
    logic        ordy;
    logic        ov;
    logic [15:0] dat;
    logic [2:0]  cnt;
    logic        ir;
    logic        af;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [15:0] dat,
                           input logic [2:0] cnt, input logic ir, input logic af);
    chk({tag, "_ov"},  32'(out_valid),   32'(ov));
    chk({tag, "_cnt"}, 32'(count),       32'(cnt));
    chk({tag, "_ir"},  32'(in_ready),    32'(ir));
    chk({tag, "_af"},  32'(almost_full), 32'(af));
    if (ov) chk({tag, "_dat"}, 32'(out_data), 32'(dat));
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] prev;
    logic        mpush, mpop;

    // inputs this cycle -> expected outputs after the edge
    vecs.push_back('{1'b1, 8'hB0, 8'h12, 1'b0, 1'b1, 16'hB012, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 16'h0100, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 8'h00, 1'b0, 1'b1, 16'h0100, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 16'h0100, 3'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'h04, 8'h00, 1'b0, 1'b1, 16'h0100, 3'd4, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h05, 8'h00, 1'b0, 1'b1, 16'h0100, 3'd4, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0200, 3'd3, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0300, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 16'h0400, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hA1, 8'h01, 1'b1, 1'b1, 16'hA101, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hA2, 8'h02, 1'b1, 1'b1, 16'hA202, 3'd1, 1'b1, 1'b0});

    // reset state, sampled while reset is held
    #2;
    chk_state("reset", 1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].iv; in_left = vecs[i].l; in_right = vecs[i].r;
      out_ready = vecs[i].ordy;
      step();
      chk_state($sformatf("vec%0d", i), vecs[i].ov, vecs[i].dat, vecs[i].cnt,
                vecs[i].ir, vecs[i].af);
    end

    // continuous push+pop at count=1 through several pointer wraps
    prev = 16'hA202;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_left = 8'(8'h10 + i); in_right = 8'(8'hC0 + i);
      chk($sformatf("wrap%0d_dat", i), 32'(out_data), 32'(prev));
      chk($sformatf("wrap%0d_cnt", i), 32'(count), 32'd1);
      step();
      prev = {in_left, in_right};
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_end_dat", 32'(out_data), 32'(prev));
    chk("wrap_end_cnt", 32'(count), 32'd1);

    // asynchronous reset mid-operation with 3 entries held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_left = 8'(8'h70 + i); in_right = 8'h33;
      step();
    end
    in_valid = 1'b0;
    chk("midrst_pre_cnt", 32'(count), 32'd3);
    #3 resetn = 1'b0;
    #1;
    chk_state("midrst", 1'b0, 16'h0, 3'd0, 1'b1, 1'b0);
    step(); step();
    resetn = 1'b1;
    in_valid = 1'b1; in_left = 8'h5A; in_right = 8'hA5;
    step();
    in_valid = 1'b0;
    chk_state("postrst", 1'b1, 16'h5AA5, 3'd1, 1'b1, 1'b0);

    // randomized traffic against a queue model
    do_reset();
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_left   = 8'($urandom);
      in_right  = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < ((n % 1000) < 500 ? 30 : 80));
      mpush = in_valid && (q.size() < DEPTH);
      mpop  = out_ready && (q.size() > 0);
      step();
      if (mpop)  void'(q.pop_front());
      if (mpush) q.push_back({in_left, in_right});
      chk_state($sformatf("rnd%0d", n), q.size() != 0, (q.size() != 0) ? q[0] : 16'h0,
                3'(q.size()), q.size() != DEPTH, q.size() >= DEPTH-1);
    end
    in_valid = 1'b0; out_ready = 1'b0;

`ifdef SHIFT_RESULT_FIFO_STATS_EN
    do_reset();
    chk("stats_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("stats_rst_ovf", 32'(ovf_seen), 32'd0);
    in_valid = 1'b1; in_left = 8'h11; in_right = 8'h22;
    repeat (DEPTH) step();
    repeat (100) step();
    chk("stats_mid_cnt", 32'(stall_cnt), 32'd100);
    chk("stats_mid_ovf", 32'(ovf_seen), 32'd0);
    repeat (200) step();
    chk("stats_sat_cnt", 32'(stall_cnt), 32'hFF);
    chk("stats_sat_ovf", 32'(ovf_seen), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    chk("stats_drain_cnt", 32'(count), 32'd0);
    chk("stats_drain_ovf", 32'(ovf_seen), 32'd1);
    do_reset();
    chk("stats_clr_cnt", 32'(stall_cnt), 32'd0);
    chk("stats_clr_ovf", 32'(ovf_seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_result_fifo.md
Name: shift_result_fifo

Overview:
- Downstream stage of the 8-bit constant shifter (left/right shift by 3).
- Captures each pair of shift results (left result, right result) through a valid/ready handshake into a small FIFO.
- Presents the pair as one 16-bit word to the consumer with its own valid/ready handshake.
- Decouples the combinational shifter from a consumer that can stall.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, log2(DEPTH), pointer width; derived, never overridden.
- ALMOST_FULL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  shifter result pair valid.
- in_ready  out  1  FIFO can accept a pair this cycle.
- in_left  in  8  left-shift result.
- in_right  in  8  right-shift result.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  16  head entry as {left[15:8], right[7:0]}.
- count  out  AW+1  current occupancy, 0..DEPTH.
- almost_full  out  1  count >= ALMOST_FULL.

Behaviour:
- Clocking and reset:
  - All state is on the clk rising edge with asynchronous clear on resetn low.
  - Reset values: rd_ptr=0, wr_ptr=0, count=0, out_valid=0, almost_full=0, in_ready=1.
  - Storage contents are not reset; out_data is don't-care while out_valid=0.
- Flow control:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH) and depends only on count, never on out_ready. No write-through when full, even with a simultaneous pop.
  - out_valid = (count != 0), registered via count.
  - out_data is a combinational read of mem[rd_ptr].
- Latency:
  - A push into an empty FIFO gives out_valid=1 on the following cycle, with the pushed data. There is no same-cycle bypass.
  - Minimum input-to-output latency is 1 cycle.
  - Throughput is 1 pair per cycle in steady state.
- Pointers and count:
  - On push: mem[wr_ptr] <= {in_left,in_right}, then wr_ptr increments modulo DEPTH.
  - On pop: rd_ptr increments modulo DEPTH.
  - Count: +1 on push only, -1 on pop only, unchanged on push&pop or on neither.
  - Pointers wrap naturally from DEPTH-1 to 0.
- Boundary conditions:
  - Full (count=DEPTH): in_ready=0. in_valid is ignored; the source must hold data stable until accepted.
  - Empty (count=0): out_valid=0, and out_ready is ignored.
  - Push and pop in the same cycle at count=1: count stays 1, and the head advances to the new entry.
  - Reset asserted mid-operation clears occupancy immediately (asynchronously). In-flight entries are discarded. No push or pop occurs while resetn=0.
- Handshake rules:
  - out_valid, once high, stays high until popped, unless reset.
  - out_data is stable while out_valid=1 and out_ready=0.
- almost_full is combinational from count.

Optional Feature:
- Macro: SHIFT_RESULT_FIFO_STATS_EN.
- Defined:
  - Adds output stall_cnt [7:0].
  - Increments by 1 each cycle with in_valid=1 and in_ready=0.
  - Saturates at 0xFF and is reset to 0.
  - Adds output ovf_seen [0:0], a sticky flag set the first time stall_cnt saturates, cleared only by reset.
- Not defined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset, then one push: resetn low then high, then in_valid=1, in_left=0xB0, in_right=0x12 (A=0x96) for 1 cycle. Required: out_valid=1 next cycle, out_data=0xB012, count=1, then count=0 after one cycle with out_ready=1.
- Fill to full with out_ready=0: push 0x01..0x04 into the left byte, right byte=0x00. Required: count steps 1,2,3,4; almost_full=1 at count 3; in_ready=0 at count 4; a 5th pushed value is not stored.
- Drain after full: out_ready=1 for 4 cycles. Required: out_data reads 0x0100,0x0200,0x0300,0x0400 in order; out_valid=0 afterwards; in_ready=1.
- Simultaneous push/pop with pointer wrap: count=1, then continuous push and pop for 10 cycles with incrementing data. Required: count stays 1, every output matches input delayed by 1 cycle, and pointers pass through wrap with no loss.
- Reset mid-operation: count=3, assert resetn low asynchronously between edges. Required: out_valid=0, count=0 and in_ready=1 immediately; after release the first output is the first new push.
- With SHIFT_RESULT_FIFO_STATS_EN: hold the FIFO full with in_valid=1 for 300 cycles. Required: stall_cnt saturates at 0xFF, ovf_seen=1, and ovf_seen stays 1 after draining until reset.
